pfd_digital_lock: RTL and testbench
===================================

Name: pfd_digital_lock

Overview:
- Clocked, parametrised successor to the asynchronous tri-state PFD used in the PLL loop.
- Synchronises the reference edge input A and the feedback edge input B into the system clock domain.
- Runs a three-state PFD FSM that drives the UP/DN outputs and measures the A-to-B edge skew as a signed cycle count.
- Adds cycle-slip flagging and a lock detector with programmable tolerance, for PLL calibration and status logic.

Parameters:
- CNT_W, 8: skew counter width; magnitude saturates at 2^CNT_W-1.
- SYNC_STAGES, 2: synchroniser flops on A and B (minimum 2).
- LOCK_TOL, 2: maximum |Err| counted as an in-lock measurement.
- LOCK_CNT, 16: consecutive in-tolerance measurements required to assert Lock.

Ports:
- Clk, input, 1: system clock; all flops on rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- Enable, input, 1: block enable; low forces idle.
- A, input, 1: reference edge input, asynchronous to Clk.
- B, input, 1: feedback edge input, asynchronous to Clk.
- UP, output, 1: high while A leads (charge-pump up).
- DN, output, 1: high while B leads (charge-pump down).
- Err, output, CNT_W+1: signed two's-complement skew in Clk cycles; positive means A leads.
- Err_valid, output, 1: one-cycle strobe marking a new Err value.
- Slip, output, 1: one-cycle strobe for a cycle slip.
- Lock, output, 1: lock indicator.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM in IDLE; skew counter and lock counter cleared.
  - Synchroniser and edge-history flops cleared.
- Synchronisation and edge detection:
  - A and B each pass through SYNC_STAGES flops, then one history flop.
  - a_rise = sync & ~hist; b_rise is formed the same way.
  - Latency from an input edge to its rise pulse is SYNC_STAGES+1 cycles, ±1 for sampling uncertainty.
- FSM states: IDLE, LEAD_A, LEAD_B. UP = (state==LEAD_A); DN = (state==LEAD_B). UP and DN are never both high.
- IDLE:
  - a_rise & b_rise: Err=0, Err_valid=1, stay in IDLE.
  - a_rise only: go to LEAD_A with cnt=1.
  - b_rise only: go to LEAD_B with cnt=1.
- LEAD_A:
  - Each cycle with no closing edge: cnt = cnt+1, saturating at 2^CNT_W-1.
  - b_rise & ~a_rise: Err=+cnt, Err_valid=1, go to IDLE.
  - b_rise & a_rise: Err=+cnt, Err_valid=1, stay in LEAD_A with cnt=1. The new A edge opens a new measurement.
  - a_rise & ~b_rise: Slip=1, no Err_valid, cnt=1, stay in LEAD_A.
- LEAD_B: mirror of LEAD_A with A and B swapped and Err = -cnt.
- Timing:
  - Err and Err_valid are registered on the same Clk edge at which the FSM leaves or re-enters the lead state.
  - A skew of k rise-pulse cycles gives exactly k cycles of UP (or DN) and |Err| = k.
  - Err holds its last value between strobes.
- Saturated count: Err = ±(2^CNT_W-1); no wrap-around.
- Lock detector, evaluated on each Err_valid or Slip:
  - |Err| <= LOCK_TOL: good count increments, saturating at LOCK_CNT.
  - Lock = 1 on the cycle after good count reaches LOCK_CNT.
  - |Err| > LOCK_TOL or Slip: good count = 0, Lock = 0 on the next cycle.
- Enable low, synchronous:
  - FSM forced to IDLE; cnt and good count cleared.
  - UP, DN, Err_valid, Slip and Lock are 0; Err holds its last value.
  - Synchronisers and history flops keep running, so a level already high at re-enable produces no rise pulse.
- Reset asserted mid-measurement: all outputs go to 0 immediately (asynchronous). No Err_valid is issued for the aborted measurement.

Test Plan:
- Skew +5: A rise, then B rise 5 Clk later (CNT_W=8) -> UP high exactly 5 cycles, DN=0, Err=+5 with a single-cycle Err_valid.
- Skew -3: B leads A by 3 cycles -> DN high 3 cycles, Err=-3 (0x1FD for a 9-bit Err), Err_valid one cycle.
- Coincident edges: A and B rise on the same Clk edge -> UP=DN=0 throughout, Err=0, Err_valid=1.
- Cycle slip: two A edges 10 cycles apart with no B, then B 4 cycles after the second A -> Slip pulses once, UP stays high, final Err=+4, Lock=0.
- Lock (LOCK_CNT=4, LOCK_TOL=2): four measurements with Err=+1,-2,0,+2 -> Lock rises after the 4th strobe. A following Err=+7 -> Lock falls the next cycle.
- Saturation and reset (CNT_W=4):
  - B edge 20 cycles after A -> Err=+15.
  - New A edge, then Reset pulsed at cycle 3 of LEAD_A -> UP, Err_valid, Slip and Lock are 0 immediately, FSM in IDLE.
  - A subsequent B edge alone enters LEAD_B.

Source files
------------

// File: rtl/pfd_digital_lock.sv
// Clocked tri-state phase/frequency detector with signed skew measurement,
// cycle-slip flagging and a programmable-tolerance lock detector.
module pfd_digital_lock #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Enable,
  input  logic           A,
  input  logic           B,
  output logic           UP,
  output logic           DN,
  output logic [CNT_W:0] Err,
  output logic           Err_valid,
  output logic           Slip,
  output logic           Lock
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TOL_V    = CNT_W'(LOCK_TOL);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {IDLE, LEAD_A, LEAD_B} state_t;

  logic [SYNC_STAGES-1:0] a_sync_q, b_sync_q;
  logic                   a_hist_q, b_hist_q;
  logic                   a_rise, b_rise;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [CNT_W:0]         err_q, err_d;
  logic                   err_valid_q, err_valid_d;
  logic                   slip_q, slip_d;
  logic [GOOD_W-1:0]      good_q, good_d;
  logic                   lock_q, lock_d;
  logic [CNT_W-1:0]       meas_mag;

  // Synchronisers and edge history run regardless of Enable.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_hist_q <= 1'b0;
      b_hist_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], A};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], B};
      a_hist_q <= a_sync_q[SYNC_STAGES-1];
      b_hist_q <= b_sync_q[SYNC_STAGES-1];
    end
  end

  assign a_rise  = a_sync_q[SYNC_STAGES-1] & ~a_hist_q;
  assign b_rise  = b_sync_q[SYNC_STAGES-1] & ~b_hist_q;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_valid_d = 1'b0;
    slip_d      = 1'b0;
    meas_mag    = '0;
    good_d      = good_q;
    lock_d      = (good_q == GOOD_MAX);

    unique case (state_q)
      IDLE: begin
        if (a_rise && b_rise) begin
          err_d       = '0;
          err_valid_d = 1'b1;
        end else if (a_rise) begin
          state_d = LEAD_A;
          cnt_d   = CNT_ONE;
        end else if (b_rise) begin
          state_d = LEAD_B;
          cnt_d   = CNT_ONE;
        end
      end
      LEAD_A: begin
        if (b_rise) begin
          err_d       = {1'b0, cnt_q};
          err_valid_d = 1'b1;
          meas_mag    = cnt_q;
          // A simultaneous new A edge opens the next measurement at once.
          if (a_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (a_rise) begin
          slip_d = 1'b1;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      LEAD_B: begin
        if (a_rise) begin
          err_d       = -{1'b0, cnt_q};
          err_valid_d = 1'b1;
          meas_mag    = cnt_q;
          if (b_rise) begin
            cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else if (b_rise) begin
          slip_d = 1'b1;
          cnt_d  = CNT_ONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Lock qualification; Lock itself follows the good count one cycle later.
    if (slip_d) begin
      good_d = '0;
    end else if (err_valid_d) begin
      if (meas_mag <= TOL_V) begin
        good_d = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
      end else begin
        good_d = '0;
      end
    end

    if (!Enable) begin
      state_d     = IDLE;
      cnt_d       = '0;
      good_d      = '0;
      err_d       = err_q;
      err_valid_d = 1'b0;
      slip_d      = 1'b0;
      lock_d      = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
      slip_q      <= 1'b0;
      good_q      <= '0;
      lock_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      err_valid_q <= err_valid_d;
      slip_q      <= slip_d;
      good_q      <= good_d;
      lock_q      <= lock_d;
    end
  end

  assign UP        = (state_q == LEAD_A);
  assign DN        = (state_q == LEAD_B);
  assign Err       = err_q;
  assign Err_valid = err_valid_q;
  assign Slip      = slip_q;
  assign Lock      = lock_q;

endmodule

// File: tb/tb_pfd_digital_lock.sv
// Bench for pfd_digital_lock: directed skew/slip/lock/saturation/enable/reset
// scenarios plus random skews, checked against a skew-to-error reference model.
module tb_pfd_digital_lock;

  localparam int CNT_W    = 4;
  localparam int SYNC     = 2;
  localparam int LOCK_TOL = 2;
  localparam int LOCK_CNT = 4;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic           Clk = 1'b0;
  logic           Reset, Enable, A, B;
  logic           UP, DN, Err_valid, Slip, Lock;
  logic [CNT_W:0] Err;

  int checks = 0;
  int errors = 0;

  int up_tot = 0, dn_tot = 0, ev_tot = 0, slip_tot = 0, both_tot = 0;
  logic [CNT_W:0] last_err = '0;

  // Magnitudes of measurements since the last lock-clearing event.
  int hist[$];
  logic [CNT_W:0] exp_err = '0;

  pfd_digital_lock #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_TOL(LOCK_TOL), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .A(A), .B(B),
    .UP(UP), .DN(DN), .Err(Err), .Err_valid(Err_valid), .Slip(Slip), .Lock(Lock)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    #1;
    if (UP) up_tot++;
    if (DN) dn_tot++;
    if (UP && DN) both_tot++;
    if (Slip) slip_tot++;
    if (Err_valid) begin
      ev_tot++;
      last_err = Err;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic expLock();
    if (hist.size() < LOCK_CNT) return 1'b0;
    for (int i = hist.size() - LOCK_CNT; i < hist.size(); i++)
      if (hist[i] > LOCK_TOL) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [CNT_W:0] errFor(input int d);
    int mag, e;
    logic [31:0] v;
    mag = (d < 0) ? -d : d;
    if (mag > SAT) mag = SAT;
    e = (d < 0) ? -mag : mag;
    v = e;
    return v[CNT_W:0];
  endfunction

  // One measurement: the later edge arrives d cycles after the earlier one
  // (d > 0: A leads, d < 0: B leads, d == 0: coincident).
  task automatic applyStimulus(input int d, input string tag);
    int up0, dn0, ev0, sl0, bo0, mag;
    up0 = up_tot; dn0 = dn_tot; ev0 = ev_tot; sl0 = slip_tot; bo0 = both_tot;
    mag = (d < 0) ? -d : d;
    @(negedge Clk);
    if (d >= 0) A = 1'b1; else B = 1'b1;
    repeat (mag) @(negedge Clk);
    if (d >= 0) B = 1'b1; else A = 1'b1;
    repeat (8) @(negedge Clk);
    A = 1'b0; B = 1'b0;
    repeat (5) @(negedge Clk);
    exp_err = errFor(d);
    hist.push_back(mag > SAT ? SAT : mag);
    checkOutput({tag, "_strobes"}, ev_tot - ev0, 1);
    checkOutput({tag, "_err"}, {27'b0, last_err}, {27'b0, exp_err});
    checkOutput({tag, "_up_cycles"}, up_tot - up0, (d > 0) ? d : 0);
    checkOutput({tag, "_dn_cycles"}, dn_tot - dn0, (d < 0) ? -d : 0);
    checkOutput({tag, "_slip"}, sl0 == slip_tot, 1);
    checkOutput({tag, "_both"}, bo0 == both_tot, 1);
    checkOutput({tag, "_lock"}, Lock, expLock());
  endtask

  initial begin
    int up0, ev0, sl0, d;
    Reset = 1'b1; Enable = 1'b1; A = 1'b0; B = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("reset_outs", {UP, DN, Err_valid, Slip, Lock}, 0);
    checkOutput("reset_err", {27'b0, Err}, 0);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);

    applyStimulus(1, "lock1");
    applyStimulus(-2, "lock2");
    applyStimulus(0, "lock3");
    applyStimulus(2, "lock4");
    checkOutput("lock_after_4", Lock, 1);
    applyStimulus(7, "lock_bad");
    checkOutput("lock_after_bad", Lock, 0);

    applyStimulus(5, "skew_p5");
    applyStimulus(-3, "skew_m3");
    checkOutput("skew_m3_raw", {27'b0, Err}, 32'h1D);
    applyStimulus(0, "coincident");

    // Cycle slip: two A edges 10 cycles apart, B 4 cycles after the second.
    up0 = up_tot; ev0 = ev_tot; sl0 = slip_tot;
    @(negedge Clk); A = 1'b1;
    repeat (5) @(negedge Clk); A = 1'b0;
    repeat (5) @(negedge Clk); A = 1'b1;
    repeat (4) @(negedge Clk); B = 1'b1;
    repeat (8) @(negedge Clk); A = 1'b0; B = 1'b0;
    repeat (5) @(negedge Clk);
    hist.delete();
    hist.push_back(4);
    exp_err = errFor(4);
    checkOutput("slip_count", slip_tot - sl0, 1);
    checkOutput("slip_up_cycles", up_tot - up0, 14);
    checkOutput("slip_strobes", ev_tot - ev0, 1);
    checkOutput("slip_err", {27'b0, last_err}, {27'b0, exp_err});
    checkOutput("slip_lock", Lock, 0);

    applyStimulus(20, "saturate");

    // Enable low mid-measurement; a level already high must not re-trigger.
    ev0 = ev_tot;
    @(negedge Clk); A = 1'b1;
    repeat (6) @(negedge Clk);
    Enable = 1'b0;
    repeat (2) @(negedge Clk);
    hist.delete();
    checkOutput("dis_up", UP, 0);
    checkOutput("dis_lock", Lock, 0);
    checkOutput("dis_err_hold", {27'b0, Err}, {27'b0, exp_err});
    Enable = 1'b1;
    up0 = up_tot;
    repeat (6) @(negedge Clk);
    checkOutput("reen_no_up", up_tot - up0, 0);
    checkOutput("dis_no_strobe", ev_tot - ev0, 0);
    A = 1'b0;
    repeat (5) @(negedge Clk);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 1) == 1) d = int'($urandom_range(0, 6)) - 3;
      else d = int'($urandom_range(0, 40)) - 20;
      applyStimulus(d, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of LEAD_A, then a lone B edge.
    @(negedge Clk); A = 1'b1;
    for (int i = 0; i < 10 && !UP; i++) @(negedge Clk);
    checkOutput("rst_pre_up", UP, 1);
    repeat (2) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    checkOutput("rst_mid_outs", {UP, DN, Err_valid, Slip, Lock}, 0);
    checkOutput("rst_mid_err", {27'b0, Err}, 0);
    A = 1'b0;
    @(negedge Clk); Reset = 1'b0;
    repeat (5) @(negedge Clk);
    B = 1'b1;
    for (int i = 0; i < 10 && !DN; i++) @(negedge Clk);
    checkOutput("rst_then_b_dn", DN, 1);
    checkOutput("rst_then_b_up", UP, 0);
    B = 1'b0;
    repeat (3) @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
